inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, number of fetch buffer entries; legal values 2, 4, 8.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  response data valid; at most one per cycle; responses return in request order.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 out_valid  output  1  instruction available to the decode/control stage.
REQ-013 out_pc  output  32  PC of the presented instruction.
REQ-014 out_instr  output  32  presented instruction.
REQ-015 out_ready  input  1  decode consumes the presented instruction this cycle.
REQ-016 err_unexpected  output  1  sticky flag: a response arrived with nothing outstanding.

Function
REQ-017 State: fetch_pc, a DEPTH-entry in-order buffer (per entry: pc, instr, filled bit), alloc count, and discard_cnt.
REQ-018 Request accept = imem_req_valid && imem_req_ready; on accept, allocate the tail entry with pc = fetch_pc and filled = 0, and set fetch_pc <= fetch_pc + 4.
REQ-019 fetch_pc addition is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 imem_req_valid = !redirect_valid && (alloc_count + discard_cnt < DEPTH), with both counts taken from registers; a pop in the same cycle does not free credit until the next cycle.
REQ-021 imem_req_addr = fetch_pc at all times.
REQ-022 A response with discard_cnt == 0 fills the oldest unfilled entry.
REQ-023 A response with discard_cnt > 0 is dropped, and discard_cnt decrements.
REQ-024 A response with no unfilled entry and discard_cnt == 0 is dropped, and err_unexpected sets.
REQ-025 out_valid = head entry filled && !redirect_valid; out_pc and out_instr come from the head entry.
REQ-026 Pop on out_valid && out_ready.
REQ-027 Minimum latency: request accepted in cycle N, response in cycle N+1, out_valid in cycle N+2.
REQ-028 When out_valid is asserted and out_ready is low, out_valid, out_pc and out_instr hold stable.
REQ-029 Push (accept) and pop may occur in the same cycle, including with the buffer full; alloc_count is unchanged.
REQ-030 Redirect: all buffer entries are cleared, alloc_count <= 0, and fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-031 Redirect: discard_cnt <= (unfilled entries + discard_cnt) - (imem_rsp_valid ? 1 : 0).
REQ-032 Redirect: no request and no pop occur in the redirect cycle.
REQ-033 Back-to-back redirects: the last one wins; the discard accounting of REQ-031 applies each cycle.
REQ-034 Requests to the new target may issue during discarding, subject to REQ-020.
REQ-035 out_instr content is never interpreted; decode is the consumer's job.

Reset
REQ-036 On rst_n low, immediately: fetch_pc = RESET_PC, buffer empty, alloc_count = 0, discard_cnt = 0, err_unexpected = 0, out_valid = 0, imem_req_valid = 0.
REQ-037 The first request issues in the first cycle after rst_n deasserts, at address RESET_PC.
REQ-038 Reset mid-operation discards all outstanding state; responses to pre-reset requests are the environment's responsibility and are not filtered.

Verification
REQ-039 Streaming: memory always ready with 1-cycle response, out_ready = 1 -> out_pc sequence 0, 4, 8, ... with one instruction per cycle from cycle 2; err_unexpected stays 0.
REQ-040 Backpressure: out_ready = 0 for 10 cycles -> exactly DEPTH requests issued, and out_valid/out_pc/out_instr held at pc 0 throughout; release -> 0, 4 delivered in order with no loss.
REQ-041 Redirect with 2 outstanding (3-cycle memory latency), redirect_pc = 32'h0000_0102 -> both stale responses dropped, next out_pc = 32'h0000_0100, and the first new request address = 32'h0000_0100.
REQ-042 Redirect in the same cycle as a response -> that response is dropped, discard_cnt = 1, and no stale instruction ever appears on out_instr.
REQ-043 Wrap-around: RESET_PC = 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-044 Spurious imem_rsp_valid with nothing outstanding -> err_unexpected = 1 and stays 1 until rst_n is asserted; the buffer is unchanged.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: in-order instruction fetch with a DEPTH-entry buffer, redirect flushing and stale-response discard
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic        err_unexpected
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [31:0] fetch_pc;
  logic [AW-1:0] head, tail, fill_idx;
  logic [CW-1:0] alloc_cnt, fill_cnt, discard_cnt, pend;
  logic accept, pop, fill, spurious;
  always_comb begin
    pend = alloc_cnt - fill_cnt;
    tail = head + alloc_cnt[AW-1:0];
    fill_idx = head + fill_cnt[AW-1:0];
    imem_req_valid = rst_n && !redirect_valid && (alloc_cnt + discard_cnt < CW'(DEPTH));
    imem_req_addr = fetch_pc;
    accept = imem_req_valid && imem_req_ready;
    fill = imem_rsp_valid && discard_cnt == '0 && pend != '0;
    spurious = imem_rsp_valid && discard_cnt == '0 && pend == '0;
    out_valid = fill_cnt != '0 && !redirect_valid;
    out_pc = pc_q[head];
    out_instr = instr_q[head];
    pop = out_valid && out_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head <= '0;
      alloc_cnt <= '0;
      fill_cnt <= '0;
      discard_cnt <= '0;
      err_unexpected <= 1'b0;
    end else begin
      err_unexpected <= err_unexpected || spurious;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        head <= '0;
        alloc_cnt <= '0;
        fill_cnt <= '0;
        discard_cnt <= pend + discard_cnt - CW'(imem_rsp_valid && !spurious);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        head <= head + AW'(pop);
        alloc_cnt <= alloc_cnt + CW'(accept) - CW'(pop);
        fill_cnt <= fill_cnt + CW'(fill) - CW'(pop);
        discard_cnt <= discard_cnt - CW'(imem_rsp_valid && discard_cnt != '0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) pc_q[tail] <= fetch_pc;
    if (fill) instr_q[fill_idx] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch against a transaction-level fetch model
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int DEPTH = 4;
  logic clk, rst_n;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic out_valid, out_ready, err_unexpected;
  logic [31:0] out_pc, out_instr;
  inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .err_unexpected(err_unexpected)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; } vec_t;
  mreq_t mq[$];
  int cyc, epoch, alloc, recv, lat_fix, checks, errors;
  logic [31:0] exp_pc, exp_addr;
  logic err_exp;
  logic s_ov, s_acc, s_rsp;
  logic [31:0] s_pc, s_instr;
  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    chk("rst_addr", imem_req_addr, RST_PC);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    epoch++;
    alloc = 0;
    recv = 0;
    exp_pc = RST_PC;
    exp_addr = RST_PC;
    err_exp = 1'b0;
    mq.delete();
  endtask
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input logic ordy, input logic spur);
    int stale, lat, due;
    logic rsp, ev, eov;
    mreq_t f;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_req_ready = rdy;
    out_ready = ordy;
    rsp = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = rsp || spur;
    imem_rsp_data = rsp ? hsh(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    ev = !redir && (alloc + stale < DEPTH);
    eov = !redir && recv > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(ev));
    chk("req_addr", imem_req_addr, exp_addr);
    chk("out_valid", 32'(out_valid), 32'(eov));
    if (out_valid) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, hsh(out_pc));
    end
    chk("err_unexpected", 32'(err_unexpected), 32'(err_exp));
    s_ov = out_valid;
    s_pc = out_pc;
    s_instr = out_instr;
    s_acc = imem_req_valid && rdy;
    s_rsp = imem_rsp_valid;
    @(posedge clk);
    if (rsp) begin
      f = mq.pop_front();
      if (f.epoch == epoch && !redir) recv++;
    end
    if (redir) begin
      epoch++;
      alloc = 0;
      recv = 0;
      exp_pc = {rpc[31:2], 2'b00};
      exp_addr = exp_pc;
    end else begin
      if (eov && ordy) begin
        recv--;
        alloc--;
        exp_pc += 32'd4;
      end
      if (ev && rdy) begin
        lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 3));
        due = cyc + lat;
        if (mq.size() > 0 && mq[mq.size()-1].due >= due) due = mq[mq.size()-1].due + 1;
        mq.push_back('{exp_addr, epoch, due});
        alloc++;
        exp_addr += 32'd4;
      end
    end
    if (spur) err_exp = 1'b1;
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    vec_t tbl[5];
    int n;
    logic got, pv;
    logic [31:0] ppc, pins;
    checks = 0; errors = 0; cyc = 0; epoch = 0; lat_fix = 1;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    tbl[0] = '{32'h0000_0102, 32'h0000_0100};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tbl[2] = '{32'h0000_0003, 32'h0000_0000};
    tbl[3] = '{32'h1234_5677, 32'h1234_5674};
    tbl[4] = '{32'h8000_0001, 32'h8000_0000};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      chk("stream_valid", 32'(s_ov), 32'(i >= 2));
      if (i >= 2) chk("stream_pc", s_pc, RST_PC + 32'(4 * (i - 2)));
    end
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n += int'(s_acc);
      if (i >= 2) begin
        chk("bp_hold_valid", 32'(s_ov), 32'd1);
        chk("bp_hold_pc", s_pc, RST_PC);
        chk("bp_hold_instr", s_instr, hsh(RST_PC));
      end
    end
    chk("bp_req_count", 32'(n), 32'(DEPTH));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_rel0_pc", s_pc, RST_PC);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_rel1_pc", s_pc, RST_PC + 32'd4);
    lat_fix = 0;
    foreach (tbl[k]) begin
      step(1'b1, tbl[k].rpc, 1'b1, 1'b1, 1'b0);
      chk("tbl_redir_addr", imem_req_addr, tbl[k].exp_addr);
      for (int j = 0; j < 4; j++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    do_reset();
    lat_fix = 3;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b0);
    chk("rd_new_addr", imem_req_addr, 32'h0000_0100);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_ov) begin
        got = 1'b1;
        chk("rd_first_pc", s_pc, 32'h0000_0100);
      end
    end
    chk("rd_seen", 32'(got), 32'd1);
    do_reset();
    lat_fix = 2;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
    chk("same_cycle_rsp", 32'(s_rsp), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_ov) begin
        got = 1'b1;
        chk("sc_first_pc", s_pc, 32'h0000_0040);
        chk("sc_first_instr", s_instr, hsh(32'h0000_0040));
      end
    end
    chk("sc_seen", 32'(got), 32'd1);
    lat_fix = 1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && mq.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("spur_drained", 32'(mq.size()), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    pv = s_ov; ppc = s_pc; pins = s_instr;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("err_set", 32'(err_unexpected), 32'd1);
    chk("spur_valid_same", 32'(s_ov), 32'(pv));
    chk("spur_pc_same", s_pc, ppc);
    chk("spur_instr_same", s_instr, pins);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("err_sticky", 32'(err_unexpected), 32'd1);
    lat_fix = 0;
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
    do_reset();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
